// File: rtl/alu_ui_pkg.sv
// rtl/alu_ui_pkg.sv - shared phase encodings and widths for the ALU input controller
package alu_ui_pkg;

  localparam int OPND_W = 8;
  localparam int SEL_W  = 4;

  // Entry phases; the numeric value is what the display path sees on phase.
  typedef enum logic [1:0] {
    PH_ENTER_A   = 2'd0,
    PH_ENTER_B   = 2'd1,
    PH_ENTER_SEL = 2'd2,
    PH_RESULT    = 2'd3
  } phase_e;

endpackage

// File: rtl/alu_input_ctrl_if.sv
// rtl/alu_input_ctrl_if.sv - switch/button inputs and latched operand outputs of the ALU input controller
// Signals:
//   sw        slide switches (async)
//   btn_enter raw enter button (async)
//   btn_back  raw back button (async)
//   A, B      latched operands
//   select    latched ALU operation select
//   phase     current entry phase
//   valid     high only in RESULT
// Modports: master drives the switches/buttons, slave is the controller.
interface alu_input_ctrl_if;
  import alu_ui_pkg::*;

  logic [OPND_W-1:0] sw;
  logic              btn_enter;
  logic              btn_back;
  logic [OPND_W-1:0] A;
  logic [OPND_W-1:0] B;
  logic [SEL_W-1:0]  select;
  logic [1:0]        phase;
  logic              valid;

  modport master (
    output sw, btn_enter, btn_back,
    input  A, B, select, phase, valid
  );

  modport slave (
    input  sw, btn_enter, btn_back,
    output A, B, select, phase, valid
  );

endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - synchronizer plus stable-count debouncer with rising-edge pulse
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   btn_raw     asynchronous raw button level
//   level       accepted (debounced) button level
//   rise_pulse  one-cycle pulse on each accepted rising edge
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic rise_pulse
);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      cnt        <= '0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      sync1      <= btn_raw;
      sync2      <= sync1;
      rise_pulse <= 1'b0;
      if (sync2 != level) begin
        // The level must have disagreed for DEBOUNCE_CYCLES counted cycles
        // before it is accepted; the counter therefore never exceeds that value.
        if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
          level      <= sync2;
          cnt        <= '0;
          rise_pulse <= sync2;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/alu_input_ctrl.sv
// rtl/alu_input_ctrl.sv - debounced operand/select entry FSM for the board-level ALU demo
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   io          alu_input_ctrl_if.slave: sw, btn_enter, btn_back in;
//               A, B, select, phase, valid out (all registered)
module alu_input_ctrl
  import alu_ui_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  alu_input_ctrl_if.slave  io
);

  logic              enter_level;
  logic              enter_pulse;
  logic              back_level;
  logic              back_pulse;
  logic [OPND_W-1:0] sw_s1;
  logic [OPND_W-1:0] sw_sync;
  phase_e            state;
  logic [OPND_W-1:0] a_q;
  logic [OPND_W-1:0] b_q;
  logic [SEL_W-1:0]  sel_q;
  logic              valid_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_enter (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (io.btn_enter),
    .level      (enter_level),
    .rise_pulse (enter_pulse)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_back (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (io.btn_back),
    .level      (back_level),
    .rise_pulse (back_pulse)
  );

  // Switches are not debounced; they only need to be stable when enter is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_s1   <= '0;
      sw_sync <= '0;
    end else begin
      sw_s1   <= io.sw;
      sw_sync <= sw_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= PH_ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else if (enter_pulse && !back_pulse) begin
      case (state)
        PH_ENTER_A: begin
          a_q   <= sw_sync;
          state <= PH_ENTER_B;
        end
        PH_ENTER_B: begin
          b_q   <= sw_sync;
          state <= PH_ENTER_SEL;
        end
        PH_ENTER_SEL: begin
          sel_q   <= sw_sync[SEL_W-1:0];
          state   <= PH_RESULT;
          valid_q <= 1'b1;
        end
        default: begin
          // Operands are kept so the last result stays displayable.
          state   <= PH_ENTER_A;
          valid_q <= 1'b0;
        end
      endcase
    end else if (back_pulse && !enter_pulse) begin
      case (state)
        PH_ENTER_B:   state <= PH_ENTER_A;
        PH_ENTER_SEL: state <= PH_ENTER_B;
        PH_RESULT: begin
          state   <= PH_ENTER_SEL;
          valid_q <= 1'b0;
        end
        default:      state <= PH_ENTER_A;
      endcase
    end
  end

  assign io.A      = a_q;
  assign io.B      = b_q;
  assign io.select = sel_q;
  assign io.phase  = state;
  assign io.valid  = valid_q;

endmodule

// File: tb/tb_alu_input_ctrl.sv
// tb/tb_alu_input_ctrl.sv - directed plus randomized self-checking bench for alu_input_ctrl
module tb_alu_input_ctrl;

  localparam int D = 4;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  int   enter_pulses;
  int   back_pulses;

  int       m_phase;
  logic [7:0] m_a;
  logic [7:0] m_b;
  logic [3:0] m_sel;

  alu_input_ctrl_if bus ();

  alu_input_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (dut.u_enter.rise_pulse === 1'b1) enter_pulses++;
    if (dut.u_back.rise_pulse === 1'b1) back_pulses++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_a     = 8'h00;
    m_b     = 8'h00;
    m_sel   = 4'h0;
  endtask

  // One accepted button event, described by the user-level rules only.
  task automatic model_event(input bit en, input bit bk, input logic [7:0] swv);
    if (en && !bk) begin
      if (m_phase == 0) m_a = swv;
      else if (m_phase == 1) m_b = swv;
      else if (m_phase == 2) m_sel = swv[3:0];
      m_phase = (m_phase + 1) % 4;
    end else if (bk && !en) begin
      if (m_phase > 0) m_phase = m_phase - 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_phase"}, 32'(bus.phase), 32'(m_phase));
    chk({tag, "_A"}, 32'(bus.A), 32'(m_a));
    chk({tag, "_B"}, 32'(bus.B), 32'(m_b));
    chk({tag, "_sel"}, 32'(bus.select), 32'(m_sel));
    chk({tag, "_valid"}, 32'(bus.valid), 32'(m_phase == 3));
  endtask

  // Clean press: sw settles, button(s) rise, check latency, release fully.
  task automatic press(input string tag, input bit en, input bit bk, input logic [7:0] swv);
    int e0, b0;
    bus.sw = swv;
    ticks(3);
    bus.btn_enter = en;
    bus.btn_back  = bk;
    e0 = enter_pulses;
    b0 = back_pulses;
    ticks(D + 3);
    chk({tag, "_enter_pulse_at_D+2"}, 32'(dut.u_enter.rise_pulse), 32'(en));
    chk({tag, "_back_pulse_at_D+2"}, 32'(dut.u_back.rise_pulse), 32'(bk));
    check_all({tag, "_before"});
    tick();
    model_event(en, bk, swv);
    check_all({tag, "_after"});
    ticks(6);
    chk({tag, "_enter_pulse_count"}, 32'(enter_pulses - e0), 32'(en));
    chk({tag, "_back_pulse_count"}, 32'(back_pulses - b0), 32'(bk));
    bus.btn_enter = 1'b0;
    bus.btn_back  = 1'b0;
    ticks(D + 4);
    check_all({tag, "_released"});
  endtask

  initial begin
    int e0;
    logic [7:0] r;
    int bounce [6];
    vectors      = 0;
    miscompares  = 0;
    enter_pulses = 0;
    back_pulses  = 0;
    bus.sw        = 8'h00;
    bus.btn_enter = 1'b0;
    bus.btn_back  = 1'b0;
    reset = 1'b1;
    model_reset();
    ticks(3);
    reset = 1'b0;
    check_all("reset");
    for (int i = 0; i < 20; i++) begin
      tick();
      check_all("idle");
    end

    press("full_a", 1'b1, 1'b0, 8'h3C);
    press("full_b", 1'b1, 1'b0, 8'hA5);
    press("full_s", 1'b1, 1'b0, 8'hF7);
    chk("full_A_const", 32'(bus.A), 32'h3C);
    chk("full_B_const", 32'(bus.B), 32'hA5);
    chk("full_sel_const", 32'(bus.select), 32'h7);
    chk("full_phase_const", 32'(bus.phase), 32'd3);
    chk("full_valid_const", 32'(bus.valid), 32'd1);

    press("back1", 1'b0, 1'b1, 8'h11);
    chk("back1_phase_const", 32'(bus.phase), 32'd2);
    press("back2", 1'b0, 1'b1, 8'h22);
    chk("back2_phase_const", 32'(bus.phase), 32'd1);
    chk("back2_A_kept", 32'(bus.A), 32'h3C);
    press("back3", 1'b0, 1'b1, 8'h33);
    press("back_in_a", 1'b0, 1'b1, 8'h44);
    chk("back_in_a_phase_const", 32'(bus.phase), 32'd0);

    // Short glitch: 3 cycles high never qualifies.
    e0 = enter_pulses;
    bus.sw = 8'h5A;
    bus.btn_enter = 1'b1;
    ticks(3);
    bus.btn_enter = 1'b0;
    ticks(12);
    chk("glitch_pulses", 32'(enter_pulses - e0), 32'd0);
    check_all("glitch");

    // Bounce 1,0,1,1,1,1 then held: exactly one accepted press.
    bounce = '{1, 0, 1, 1, 1, 1};
    e0 = enter_pulses;
    for (int i = 0; i < 6; i++) begin
      bus.btn_enter = bounce[i][0];
      tick();
    end
    ticks(14);
    model_event(1'b1, 1'b0, 8'h5A);
    chk("bounce_pulses", 32'(enter_pulses - e0), 32'd1);
    check_all("bounce");
    bus.btn_enter = 1'b0;
    ticks(D + 4);

    press("simul", 1'b1, 1'b1, 8'h99);

    for (int k = 0; k < 30; k++) begin
      r = 8'($urandom);
      case ($urandom_range(0, 3))
        0, 1: press("rand_enter", 1'b1, 1'b0, r);
        2:    press("rand_back", 1'b0, 1'b1, r);
        default: press("rand_both", 1'b1, 1'b1, r);
      endcase
    end

    // Reset while enter is held mid-debounce: re-qualified from scratch.
    r = 8'($urandom);
    bus.sw = r;
    ticks(3);
    bus.btn_enter = 1'b1;
    ticks(4);
    reset = 1'b1;
    ticks(2);
    model_reset();
    check_all("rst_held");
    reset = 1'b0;
    e0 = enter_pulses;
    ticks(D + 2);
    chk("rst_no_early_pulse", 32'(enter_pulses - e0), 32'd0);
    tick();
    chk("rst_pulse_at_D+2", 32'(dut.u_enter.rise_pulse), 32'd1);
    check_all("rst_before");
    tick();
    model_event(1'b1, 1'b0, r);
    check_all("rst_after");
    chk("rst_phase_const", 32'(bus.phase), 32'd1);
    bus.btn_enter = 1'b0;
    ticks(D + 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
